// File: rtl/adder4_result_accum.sv
// Sums NSAMP 5-bit adder results per batch and presents total, count and a sticky overflow flag.
// Result valid 1 cycle after the last accept; the input stalls (in_ready=0) until the batch is taken.
module adder4_result_accum #(
    parameter  int NSAMP = 8,
    parameter  int ACC_W = 8,
    localparam int CNT_W = $clog2(NSAMP + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       sum_in,
    input  logic             carry_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] count_out,
    output logic             overflow
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic [ACC_W:0]   w_val;
    logic [ACC_W:0]   w_sum;

    // One extra bit on the adder exposes the wrap out of the accumulator's MSB.
    assign w_val = {{(ACC_W - 4){1'b0}}, carry_in, sum_in};
    assign w_sum = {1'b0, r_acc} + w_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        case (r_state)
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_acc_nxt = w_sum[ACC_W-1:0];
                    w_ovf_nxt = r_ovf | w_sum[ACC_W];
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(NSAMP - 1)) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_ACC;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_ACC;
            end
        endcase

        // Abort overrides any handshake in the same cycle, dropping a coincident sample.
        if (clear) begin
            w_state_nxt = ST_ACC;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end
    end

    assign acc_out   = r_acc;
    assign count_out = r_cnt;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_adder4_result_accum.sv
// Bench for adder4_result_accum: directed cases, a narrow-accumulator instance and a scoreboarded random run.
module tb_adder4_result_accum;

    localparam int NS = 8;
    localparam int AW = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sum_in;
    logic       carry_in;
    logic       in_valid;
    logic       in_ready;
    logic       clear;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] acc_out;
    logic [3:0] count_out;
    logic       overflow;

    logic [3:0] b_sum_in;
    logic       b_carry_in;
    logic       b_in_valid;
    logic       b_in_ready;
    logic       b_clear;
    logic       b_out_valid;
    logic       b_out_ready;
    logic [5:0] b_acc_out;
    logic [1:0] b_count_out;
    logic       b_overflow;

    always #5 clk = ~clk;

    adder4_result_accum #(.NSAMP(NS), .ACC_W(AW)) u_dut_a (
        .clk(clk), .rst(rst), .sum_in(sum_in), .carry_in(carry_in),
        .in_valid(in_valid), .in_ready(in_ready), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .count_out(count_out), .overflow(overflow)
    );

    adder4_result_accum #(.NSAMP(3), .ACC_W(6)) u_dut_b (
        .clk(clk), .rst(rst), .sum_in(b_sum_in), .carry_in(b_carry_in),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .clear(b_clear),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .acc_out(b_acc_out),
        .count_out(b_count_out), .overflow(b_overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_batches;

    // Reference model of instance A
    int         m_acc;
    int         m_cnt;
    logic       m_ovf;
    logic       m_hold;
    logic [8:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_acc  = 0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_hold = 1'b0;
    endtask

    // Drive one cycle on instance A (entered and left at posedge+1), scoreboarding batch results.
    task automatic step(input logic v, input logic [4:0] d, input logic ordy, input logic clr);
        logic [8:0] exp_b;
        int         s;
        in_valid  = v;
        {carry_in, sum_in} = d;
        out_ready = ordy;
        clear     = clr;
        #1;
        check("in_ready", in_ready, m_hold ? 0 : 1);
        check("out_valid", out_valid, m_hold ? 1 : 0);
        if (out_valid && ordy && !clr) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_out", out_valid, 0);
            end else begin
                exp_b = sb.pop_front();
                check("batch_acc", acc_out, exp_b[7:0]);
                check("batch_ovf", overflow, exp_b[8]);
                check("batch_cnt", count_out, NS);
                n_batches++;
            end
        end
        if (clr) begin
            if (m_hold && sb.size() != 0) void'(sb.pop_back());
            model_clear();
        end else if (!m_hold) begin
            if (v) begin
                s     = m_acc + int'(d);
                m_ovf = m_ovf | (s > 255);
                m_acc = s % 256;
                m_cnt++;
                if (m_cnt == NS) begin
                    m_hold = 1'b1;
                    sb.push_back({m_ovf, 8'(m_acc)});
                end
            end
        end else if (ordy) begin
            model_clear();
        end
        @(posedge clk);
        #1;
        check("acc", acc_out, m_acc);
        check("cnt", count_out, m_cnt);
        check("ovf", overflow, m_ovf);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        sum_in = '0; carry_in = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        b_sum_in = '0; b_carry_in = 1'b0; b_in_valid = 1'b0; b_clear = 1'b0; b_out_ready = 1'b0;
        model_clear();
        n_batches = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc", acc_out, 0);
        check("rst_cnt", count_out, 0);
        check("rst_ovf", overflow, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full batch of value 31
        for (int i = 0; i < NS; i++) step(1'b1, 5'd31, 1'b0, 1'b0);
        check("full_acc", acc_out, 248);
        check("full_cnt", count_out, 8);
        check("full_ovf", overflow, 0);
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);

        // HOLD ignores input while out_ready stays low
        for (int i = 0; i < 5; i++) step(1'b1, 5'd3, 1'b0, 1'b0);
        check("hold_acc", acc_out, 248);
        step(1'b0, 5'd0, 1'b1, 1'b0);
        check("rel_out_valid", out_valid, 0);
        check("rel_in_ready", in_ready, 1);
        check("rel_acc", acc_out, 0);

        // Clear coinciding with a valid sample drops that sample
        step(1'b1, 5'd5, 1'b0, 1'b0);
        step(1'b1, 5'd10, 1'b0, 1'b0);
        step(1'b1, 5'd2, 1'b0, 1'b0);
        check("pre_clear_acc", acc_out, 17);
        step(1'b1, 5'd7, 1'b0, 1'b1);
        check("clear_acc", acc_out, 0);
        check("clear_cnt", count_out, 0);
        check("clear_ovf", overflow, 0);

        // Narrow accumulator instance: 3 x 31 into 6 bits
        b_in_valid = 1'b1;
        {b_carry_in, b_sum_in} = 5'd31;
        @(posedge clk); #1;
        check("b_s1_acc", b_acc_out, 31);
        @(posedge clk); #1;
        check("b_s2_acc", b_acc_out, 62);
        check("b_s2_ovf", b_overflow, 0);
        @(posedge clk); #1;
        check("b_s3_acc", b_acc_out, 29);
        check("b_s3_ovf", b_overflow, 1);
        check("b_s3_out_valid", b_out_valid, 1);
        check("b_s3_cnt", b_count_out, 3);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        check("b_rel_out_valid", b_out_valid, 0);
        b_out_ready = 1'b0;

        // Random gaps and backpressure, 50 batches
        n_batches = 0;
        cyc = 0;
        while (n_batches < 50 && cyc < 5000) begin
            step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom_range(0, 9) < 4, 1'b0);
            cyc++;
        end
        check("rand_batches", n_batches, 50);

        // Async reset while in HOLD, observed before the next edge
        cyc = 0;
        while (!m_hold && cyc < 20) begin
            step(1'b1, 5'd20, 1'b0, 1'b0);
            cyc++;
        end
        check("pre_arst_out_valid", out_valid, 1);
        rst = 1'b1;
        #2;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_acc", acc_out, 0);
        check("arst_cnt", count_out, 0);
        check("arst_ovf", overflow, 0);
        model_clear();
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 5'd9, 1'b0, 1'b0);
        check("post_arst_acc", acc_out, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
